// File: rtl/pipe_stage_buffer_pkg.sv
// rtl/pipe_stage_buffer_pkg.sv - shared types and occupancy helper for LC-3b pipeline stage buffers
package pipe_stage_buffer_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } stage_occ_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
    } if_id_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] sr1;
        logic [15:0] sr2;
    } id_ex_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] alu;
        logic [15:0] sr2;
    } ex_mem_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] result;
    } mem_wb_t;

    // Stage instances pass these as WIDTH so payload changes resize the buffers automatically
    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Next occupancy of the two-entry buffer, ignoring flush
    function automatic stage_occ_t occ_after(stage_occ_t occ, logic in_fire, logic out_fire);
        case (occ)
            OCC_EMPTY: return in_fire ? OCC_ONE : OCC_EMPTY;
            OCC_ONE: begin
                if (in_fire && !out_fire) return OCC_TWO;
                if (!in_fire && out_fire) return OCC_EMPTY;
                return OCC_ONE;
            end
            OCC_TWO:   return out_fire ? OCC_ONE : OCC_TWO;
            default:   return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - valid/ready pipeline stage with optional skid entry, flush and stall counter
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    stage_occ_t             occ_q;
    logic [WIDTH-1:0]       main_q;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   in_fire;
    logic                   out_fire;

    // The main entry is always the head; out_data reads zero after reset or flush
    assign out_valid    = (occ_q != OCC_EMPTY);
    assign out_data     = main_q;
    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;
    assign in_fire      = in_valid & in_ready;
    assign out_fire     = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid_q;
            logic             in_ready_q;
            stage_occ_t       occ_next;

            // Flush overrides every transition, including a same-cycle accept
            always_comb begin
                occ_next = flush ? OCC_EMPTY : occ_after(occ_q, in_fire, out_fire);
            end

            // in_ready comes straight from a flop, cutting the out_ready -> in_ready path
            assign in_ready = in_ready_q;

            // Main/skid storage: arrivals go to main when it frees up, else to skid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    occ_q      <= OCC_EMPTY;
                    main_q     <= '0;
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    occ_q      <= occ_next;
                    in_ready_q <= (occ_next != OCC_TWO);
                    if (flush) begin
                        main_q <= '0;
                        skid_q <= '0;
                    end else begin
                        case (occ_q)
                            OCC_EMPTY: if (in_fire) main_q <= in_data;
                            OCC_ONE: begin
                                if (in_fire && out_fire) main_q <= in_data;
                                else if (in_fire)        skid_q <= in_data;
                            end
                            OCC_TWO:   if (out_fire) main_q <= skid_q;
                            default:   ;
                        endcase
                    end
                end
            end
        end else begin : g_single
            // Single entry accepts whenever it is empty or draining this cycle
            assign in_ready = ~out_valid | out_ready;

            // Single entry: a simultaneous accept and drain replaces the payload
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    occ_q  <= OCC_EMPTY;
                    main_q <= '0;
                end else if (flush) begin
                    occ_q  <= OCC_EMPTY;
                    main_q <= '0;
                end else if (in_fire) begin
                    occ_q  <= OCC_ONE;
                    main_q <= in_data;
                end else if (out_fire) begin
                    occ_q  <= OCC_EMPTY;
                end
            end
        end
    endgenerate

    // Saturating count of cycles the head entry is blocked downstream; flush does not clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule
